// File: rtl/pc_stack_if.sv
// Execute-bus and stack-status bundle between the core sequencer and pc_stack.
// master drives the execute state and PC; slave is the stack itself.
`ifndef PC_WIDTH
`define PC_WIDTH 9
`endif
`ifndef EX_STATE_BITS
`define EX_STATE_BITS 4
`endif

interface pc_stack_if #(
   parameter int PC_W  = `PC_WIDTH,
   parameter int CNT_W = 2
) ();
   logic [`EX_STATE_BITS-1:0] executeState;
   logic [PC_W-1:0]           pcIn;
   logic                      clrErr;
   logic [PC_W-1:0]           stackOut;
   logic [CNT_W-1:0]          level;
   logic                      overflow;
   logic                      underflow;

   modport master (
      output executeState, pcIn, clrErr,
      input  stackOut, level, overflow, underflow
   );

   modport slave (
      input  executeState, pcIn, clrErr,
      output stackOut, level, overflow, underflow
   );
endinterface

// File: rtl/pc_stack.sv
// PIC16C5x return-address stack; push on EX_Q4_CALL, pop on EX_Q4_RETLW.
// Define PC_STACK_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
`ifndef PC_WIDTH
`define PC_WIDTH 9
`endif
`ifndef EX_STATE_BITS
`define EX_STATE_BITS 4
`endif
`ifndef EX_Q2
`define EX_Q2 4'h1
`endif
`ifndef EX_Q4_GOTO
`define EX_Q4_GOTO 4'h8
`endif
`ifndef EX_Q4_CALL
`define EX_Q4_CALL 4'h9
`endif
`ifndef EX_Q4_RETLW
`define EX_Q4_RETLW 4'hA
`endif

module pc_stack #(
   parameter int PC_W  = `PC_WIDTH,
   parameter int DEPTH = 2,
   parameter int CNT_W = 2
) (
   input  logic       clk,
   input  logic       rst,
   pc_stack_if.slave  bus
);

   logic [PC_W-1:0]  e [DEPTH];
   logic [CNT_W-1:0] cnt;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;

   assign push  = (bus.executeState == `EX_Q4_CALL);
   assign pop   = (bus.executeState == `EX_Q4_RETLW);
   assign full  = (cnt == CNT_W'(DEPTH));
   assign empty = (cnt == '0);

   // Entries shift even at full/empty; only the count saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) e[i] <= '0;
         cnt <= '0;
      end else if (push) begin
         e[0] <= bus.pcIn;
         for (int i = 1; i < DEPTH; i++) e[i] <= e[i-1];
         if (!full) cnt <= cnt + 1'b1;
      end else if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) e[i] <= e[i+1];
         if (!empty) cnt <= cnt - 1'b1;
      end
   end

   assign bus.stackOut = e[0];
   assign bus.level    = cnt;

`ifdef PC_STACK_ERR_FLAGS_EN
   logic ovf;
   logic unf;

   // A new error event wins over a coincident clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         if (push && full)      ovf <= 1'b1;
         else if (bus.clrErr)   ovf <= 1'b0;
         if (pop && empty)      unf <= 1'b1;
         else if (bus.clrErr)   unf <= 1'b0;
      end
   end

   assign bus.overflow  = ovf;
   assign bus.underflow = unf;
`else
   wire unused_clr = bus.clrErr;

   assign bus.overflow  = 1'b0;
   assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack against a queue-based stack model.
// Flag expectations follow PC_STACK_ERR_FLAGS_EN as seen by the bench.
`ifndef EX_STATE_BITS
`define EX_STATE_BITS 4
`endif
`ifndef EX_Q2
`define EX_Q2 4'h1
`endif
`ifndef EX_Q4_GOTO
`define EX_Q4_GOTO 4'h8
`endif
`ifndef EX_Q4_CALL
`define EX_Q4_CALL 4'h9
`endif
`ifndef EX_Q4_RETLW
`define EX_Q4_RETLW 4'hA
`endif

module tb_pc_stack;
   localparam int D = 2;
`ifdef PC_STACK_ERR_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   pc_stack_if #(.PC_W(9), .CNT_W(2)) bus ();

   pc_stack #(.PC_W(9), .DEPTH(D), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: fixed-size queue, front is the top of stack.
   logic [8:0] mq[$];
   int         mlvl;
   bit         movf;
   bit         mund;

   task automatic model_reset();
      mq = {};
      for (int i = 0; i < D; i++) mq.push_back(9'h0);
      mlvl = 0;
      movf = 0;
      mund = 0;
   endtask

   task automatic set_in(input logic r, input logic [3:0] st,
                         input logic [8:0] pc, input logic c);
      @(negedge clk);
      rst = r;
      bus.executeState = st;
      bus.pcIn = pc;
      bus.clrErr = c;
   endtask

   task automatic tick();
      logic [8:0] b;
      bit ov_ev;
      bit un_ev;
      @(posedge clk);
      ov_ev = 0;
      un_ev = 0;
      if (rst) begin
         model_reset();
      end else begin
         if (bus.executeState == `EX_Q4_CALL) begin
            ov_ev = (mlvl == D);
            mq.push_front(bus.pcIn);
            void'(mq.pop_back());
            if (mlvl < D) mlvl++;
         end else if (bus.executeState == `EX_Q4_RETLW) begin
            un_ev = (mlvl == 0);
            b = mq[$];
            void'(mq.pop_front());
            mq.push_back(b);
            if (mlvl > 0) mlvl--;
         end
         if (FL) begin
            if (ov_ev) movf = 1;
            else if (bus.clrErr) movf = 0;
            if (un_ev) mund = 1;
            else if (bus.clrErr) mund = 0;
         end
      end
      #1;
   endtask

   task automatic cyc(input logic r, input logic [3:0] st,
                      input logic [8:0] pc, input logic c);
      set_in(r, st, pc, c);
      tick();
   endtask

   task automatic test_reset();
      cyc(1, `EX_Q4_CALL, 9'h055, 0);
      cyc(1, `EX_Q4_CALL, 9'h055, 0);
      tests++;
      if (bus.stackOut !== 9'h0 || bus.level !== 2'd0 ||
          bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
         fails++;
         $display("FAIL reset: out=%h lvl=%0d ov=%b un=%b want 0/0/0/0",
                  bus.stackOut, bus.level, bus.overflow, bus.underflow);
      end
   endtask

   task automatic test_push_pop();
      cyc(0, `EX_Q4_CALL, 9'h012, 0);
      tests++;
      if (bus.stackOut !== 9'h012 || bus.level !== 2'd1) begin
         fails++;
         $display("FAIL push1: out=%h lvl=%0d want 012/1",
                  bus.stackOut, bus.level);
      end
      set_in(0, `EX_Q4_RETLW, 9'h0, 0);
      #1;
      tests++;
      if (bus.stackOut !== 9'h012) begin
         fails++;
         $display("FAIL retlw_read: out=%h want 012", bus.stackOut);
      end
      tick();
      tests++;
      if (bus.level !== 2'd0 || bus.underflow !== 1'b0) begin
         fails++;
         $display("FAIL pop1: lvl=%0d un=%b want 0/0",
                  bus.level, bus.underflow);
      end
   endtask

   task automatic test_two_push();
      cyc(0, `EX_Q4_CALL, 9'h010, 0);
      cyc(0, `EX_Q4_CALL, 9'h020, 0);
      tests++;
      if (bus.stackOut !== 9'h020 || bus.level !== 2'd2) begin
         fails++;
         $display("FAIL push2: out=%h lvl=%0d want 020/2",
                  bus.stackOut, bus.level);
      end
      cyc(0, `EX_Q4_RETLW, 9'h0, 0);
      tests++;
      if (bus.stackOut !== 9'h010 || bus.level !== 2'd1) begin
         fails++;
         $display("FAIL pop2a: out=%h lvl=%0d want 010/1",
                  bus.stackOut, bus.level);
      end
      cyc(0, `EX_Q4_RETLW, 9'h0, 0);
      tests++;
      if (bus.stackOut !== 9'h010 || bus.level !== 2'd0) begin
         fails++;
         $display("FAIL pop2b: out=%h lvl=%0d want 010/0",
                  bus.stackOut, bus.level);
      end
   endtask

   task automatic test_overflow();
      cyc(0, `EX_Q4_CALL, 9'h001, 0);
      cyc(0, `EX_Q4_CALL, 9'h002, 0);
      tests++;
      if (bus.overflow !== 1'b0) begin
         fails++;
         $display("FAIL ovf_early: ov=%b want 0", bus.overflow);
      end
      cyc(0, `EX_Q4_CALL, 9'h003, 0);
      tests++;
      if (bus.stackOut !== 9'h003 || bus.level !== 2'd2 ||
          bus.overflow !== FL) begin
         fails++;
         $display("FAIL ovf: out=%h lvl=%0d ov=%b want 003/2/%b",
                  bus.stackOut, bus.level, bus.overflow, FL);
      end
      cyc(0, `EX_Q4_RETLW, 9'h0, 0);
      tests++;
      if (bus.stackOut !== 9'h002) begin
         fails++;
         $display("FAIL ovf_pop1: out=%h want 002", bus.stackOut);
      end
      cyc(0, `EX_Q4_RETLW, 9'h0, 0);
      tests++;
      if (bus.stackOut !== 9'h002 || bus.level !== 2'd0 ||
          bus.overflow !== FL) begin
         fails++;
         $display("FAIL ovf_pop2: out=%h lvl=%0d ov=%b want 002/0/%b",
                  bus.stackOut, bus.level, bus.overflow, FL);
      end
   endtask

   task automatic test_underflow_clear();
      cyc(0, `EX_Q4_RETLW, 9'h0, 0);
      tests++;
      if (bus.underflow !== FL || bus.level !== 2'd0 ||
          bus.stackOut !== mq[0]) begin
         fails++;
         $display("FAIL unf: un=%b lvl=%0d out=%h want %b/0/%h",
                  bus.underflow, bus.level, bus.stackOut, FL, mq[0]);
      end
      cyc(0, `EX_Q2, 9'h0, 1);
      tests++;
      if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
         fails++;
         $display("FAIL clr: un=%b ov=%b want 0/0",
                  bus.underflow, bus.overflow);
      end
      cyc(0, `EX_Q4_RETLW, 9'h0, 1);
      tests++;
      if (bus.underflow !== FL) begin
         fails++;
         $display("FAIL clr_vs_set: un=%b want %b", bus.underflow, FL);
      end
   endtask

   task automatic test_hold();
      logic [8:0] top;
      cyc(0, `EX_Q4_CALL, 9'h1A5, 0);
      cyc(0, `EX_Q4_CALL, 9'h0C3, 0);
      top = mq[0];
      for (int i = 0; i < 10; i++)
         cyc(0, (i % 2) ? `EX_Q4_GOTO : `EX_Q2, 9'($urandom), 0);
      tests++;
      if (bus.stackOut !== top || bus.level !== 2'd2 ||
          bus.underflow !== FL || bus.overflow !== 1'b0) begin
         fails++;
         $display("FAIL hold: out=%h lvl=%0d un=%b ov=%b want %h/2/%b/0",
                  bus.stackOut, bus.level, bus.underflow, bus.overflow,
                  top, FL);
      end
      cyc(0, `EX_Q4_RETLW, 9'h0, 0);
      tests++;
      if (bus.stackOut !== 9'h1A5) begin
         fails++;
         $display("FAIL hold_bottom: out=%h want 1a5", bus.stackOut);
      end
      cyc(1, `EX_Q4_CALL, 9'h077, 0);
      tests++;
      if (bus.stackOut !== 9'h0 || bus.level !== 2'd0 ||
          bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
         fails++;
         $display("FAIL rst_call: out=%h lvl=%0d ov=%b un=%b want 0/0/0/0",
                  bus.stackOut, bus.level, bus.overflow, bus.underflow);
      end
      cyc(0, `EX_Q4_RETLW, 9'h0, 0);
      tests++;
      if (bus.stackOut !== 9'h0) begin
         fails++;
         $display("FAIL rst_bottom: out=%h want 0", bus.stackOut);
      end
   endtask

   task automatic test_random();
      logic [3:0] st;
      int         sel;
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 9));
         st = (sel < 4) ? `EX_Q4_CALL :
              (sel < 8) ? `EX_Q4_RETLW :
              (sel == 8) ? `EX_Q2 : 4'($urandom);
         cyc(($urandom_range(0, 49) == 0), st, 9'($urandom),
             ($urandom_range(0, 5) == 0));
         tests++;
         if (bus.stackOut !== mq[0] || bus.level !== 2'(mlvl) ||
             bus.overflow !== movf || bus.underflow !== mund) begin
            fails++;
            $display("FAIL rand[%0d]: out=%h lvl=%0d ov=%b un=%b want %h/%0d/%b/%b",
                     n, bus.stackOut, bus.level, bus.overflow,
                     bus.underflow, mq[0], mlvl, movf, mund);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.executeState = `EX_Q2;
      bus.pcIn = 9'h0;
      bus.clrErr = 1'b0;
      model_reset();
      test_reset();
      test_push_pop();
      test_two_push();
      test_overflow();
      test_underflow_clear();
      test_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Hardware return-address stack for the PIC16C5x core; the counterpart of the program-counter block.
- The PC block consumes `stackIn` on RETLW; this block produces that value. It also captures the current PC on CALL.
- Push/pop are decoded from the execute-state bus, so no extra control from the decoder is needed.
- Default depth is 2, matching the PIC16C5x two-level stack, including its overflow/underflow semantics.

Parameters:
- PC_W, default `PC_WIDTH (9): width of one stack entry.
- DEPTH, default 2: number of levels; must be >= 2.
- CNT_W, default 2: width of the occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous reset, active-high.
- executeState  input  `EX_STATE_BITS  execute-state bus from the sequencer.
- pcIn  input  PC_W  current PC register value (already holds the return address during EX_Q4_CALL).
- clrErr  input  1  single-cycle clear for the sticky error flags.
- stackOut  output  PC_W  top-of-stack entry, combinational from the level-0 register; drives the PC block's stackIn.
- level  output  CNT_W  number of valid entries, 0..DEPTH.
- overflow  output  1  sticky; set by a push while full.
- underflow  output  1  sticky; set by a pop while empty.

Behaviour:
- Storage is entries e[0..DEPTH-1]; e[0] is the top. stackOut = e[0] at all times, with no registered delay. The PC block loads stackOut in the same EX_Q4_RETLW cycle that the pop is decoded.
- Push occurs when executeState == `EX_Q4_CALL, once per cycle spent in that state. On the next edge:
  - e[0] <= pcIn; e[i] <= e[i-1] for i = 1..DEPTH-1.
  - The bottom entry is discarded.
- Pop occurs when executeState == `EX_Q4_RETLW. On the next edge:
  - e[i] <= e[i+1] for i = 0..DEPTH-2.
  - e[DEPTH-1] keeps its value (PIC behaviour: repeated returns keep re-reading the bottom entry).
- Push and pop are mutually exclusive by construction, since they are two codes of one bus. Every other state code holds all registers.
- level:
  - Increments on push, saturating at DEPTH.
  - Decrements on pop, saturating at 0.
  - Push at full: entries still shift (oldest lost) and level stays DEPTH.
  - Pop at empty: entries still shift, level stays 0, and stackOut returns whatever value was shifted up.
- Flags (see Optional Feature):
  - overflow <= 1 on a push while level == DEPTH.
  - underflow <= 1 on a pop while level == 0.
  - clrErr clears both flags on the next edge. If clrErr coincides with a new error event, the flag is set (the set wins).
- Reset (rst = 1 at a rising edge), regardless of executeState:
  - All e[i], level, overflow and underflow go to 0, so stackOut = 0.
  - Applies equally mid-instruction: a push or pop in the reset cycle is discarded.
- Latency: pushed data is visible on stackOut one cycle after the EX_Q4_CALL edge. A pop's effect is visible one cycle after the EX_Q4_RETLW edge.
- The block performs no arithmetic on addresses. Entries store pcIn verbatim, all PC_W bits.

Optional Feature:
- Macro: PC_STACK_ERR_FLAGS_EN.
- Defined: overflow/underflow registers and clrErr behave exactly as described under Behaviour.
- Undefined:
  - No flag registers are built; overflow and underflow are tied to 0.
  - clrErr is ignored.
  - Stack data and level behaviour are identical to the defined case.

Test Plan:
1. Reset: hold rst = 1 for 2 cycles with executeState = `EX_Q4_CALL and pcIn = 9'h055 -> stackOut = 0, level = 0, overflow = 0, underflow = 0.
2. Push then pop:
   - CALL with pcIn = 9'h012 -> next cycle stackOut = 9'h012, level = 1.
   - RETLW -> stackOut reads 9'h012 during the RETLW cycle; next cycle level = 0.
3. Two pushes then pops:
   - Push 9'h010, then push 9'h020 -> stackOut = 9'h020, level = 2.
   - Pop -> stackOut = 9'h010.
   - Pop -> stackOut still = 9'h010, level = 0.
4. Overflow:
   - Push 9'h001, 9'h002, 9'h003 -> level = 2, stackOut = 9'h003, overflow = 1.
   - Pop -> stackOut = 9'h002.
   - Pop -> stackOut = 9'h002.
5. Underflow and clear:
   - From empty, pop -> underflow = 1, level = 0.
   - Pulse clrErr -> underflow = 0.
   - clrErr in the same cycle as another empty pop -> underflow = 1.
6. Hold and reset:
   - Non-CALL/RETLW states (e.g. `EX_Q2, `EX_Q4_GOTO) for 10 cycles -> no change in e[], level or flags.
   - rst asserted in a CALL cycle -> push discarded, all state zero.
